updown_counter_arbiter: RTL and testbench



---
 rtl/updown_arb_pkg.sv | 26 ++
 rtl/updown_counter_arbiter_rr_arbiter.sv | 45 ++++
 rtl/updown_counter_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_updown_counter_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_arb_pkg
// Purpose  : Shared types for the arbitrated up/down counter: command opcodes
//            and the lock FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package updown_arb_pkg;

  // Command carried on each requester's 2-bit req_op slice.
  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // Arbitration mode: free round-robin, or a single owner holds the counter.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/updown_counter_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Grants the first asserted
//            request found scanning upward from ptr, wrapping modulo N.
// Ports    : req    [N]  - request vector
//            ptr    [PW] - index with highest priority this cycle
//            enable      - when low no grant is issued
//            gnt    [N]  - one-hot (or zero) grant
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import updown_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic          found;
    int            pos;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Position k steps above ptr, folded back into 0..N-1.
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/updown_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_arbiter
// Purpose  : One shared WIDTH-bit up/down counter driven by NUM_REQ
//            requesters through a valid/ready handshake with round-robin
//            arbitration and an optional exclusive lock with idle timeout.
// Ports    : clk, reset (sync, active-high)
//            req_valid/req_op/req_data/req_lock - per-requester command
//            req_ready    - one-hot grant (handshake = valid & ready)
//            count        - counter value (updates one edge after handshake)
//            grant_id     - index of last accepted requester
//            locked       - high while a requester owns the counter
//            wrap_up/wrap_down/lock_timeout - one-cycle event pulses
// Config   : UPDOWN_ARB_SAT_EN - saturating inc/dec; the wrap pulses then
//            flag overflow/underflow attempts.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_arbiter
  import updown_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 4,
  parameter int LOCK_TMO = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           count,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       wrap_up,
  output logic                       wrap_down,
  output logic                       lock_timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_TMO + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e               state, state_nx;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        owner;
  logic [TW-1:0]        tmo_cnt;
  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   gnt;
  logic                 fire;
  logic [PW-1:0]        sel;
  op_e                  sel_op;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_lock;
  logic                 tmo_hit;
  logic [WIDTH-1:0]     cnt_nx;
  logic                 wu_nx;
  logic                 wd_nx;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    next_idx = (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
  endfunction

  // While locked only the owner's request reaches the arbiter.
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    arb_req = (state == ST_LOCKED) ? (req_valid & owner_mask) : req_valid;
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req    (arb_req),
    .ptr    (ptr),
    .enable (1'b1),
    .gnt    (gnt)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;
  assign locked    = (state == ST_LOCKED);

  // Mux out the granted requester's command fields.
  always_comb begin
    sel      = '0;
    sel_op   = OP_INC;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel      = PW'(i);
        sel_op   = op_e'(req_op[2*i +: 2]);
        sel_data = req_data[WIDTH*i +: WIDTH];
        sel_lock = req_lock[i];
      end
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire && sel_lock) state_nx = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (fire) begin
          if (!sel_lock) state_nx = ST_IDLE;
        end else if (tmo_cnt == TW'(LOCK_TMO - 1)) begin
          // This idle cycle is the LOCK_TMO-th one: force release.
          state_nx = ST_IDLE;
          tmo_hit  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter datapath.
  always_comb begin
    cnt_nx = count;
    wu_nx  = 1'b0;
    wd_nx  = 1'b0;
    if (fire) begin
      case (sel_op)
        OP_INC: begin
          if (count == CNT_MAX) begin
            wu_nx = 1'b1;
`ifdef UPDOWN_ARB_SAT_EN
            cnt_nx = CNT_MAX;
`else
            cnt_nx = '0;
`endif
          end else begin
            cnt_nx = count + WIDTH'(1);
          end
        end
        OP_DEC: begin
          if (count == '0) begin
            wd_nx = 1'b1;
`ifdef UPDOWN_ARB_SAT_EN
            cnt_nx = '0;
`else
            cnt_nx = CNT_MAX;
`endif
          end else begin
            cnt_nx = count - WIDTH'(1);
          end
        end
        OP_LOAD: cnt_nx = sel_data;
        OP_CLR:  cnt_nx = '0;
        default: cnt_nx = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      tmo_cnt      <= '0;
      count        <= '0;
      grant_id     <= '0;
      wrap_up      <= 1'b0;
      wrap_down    <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= cnt_nx;
      wrap_up      <= wu_nx;
      wrap_down    <= wd_nx;
      lock_timeout <= tmo_hit;
      if (fire) grant_id <= sel;

      if (state == ST_IDLE) begin
        tmo_cnt <= '0;
        if (fire) begin
          ptr <= next_idx(sel);
          if (sel_lock) owner <= sel;
        end
      end else begin
        // ptr stays frozen while locked; release hands priority past owner.
        if (fire || tmo_hit) tmo_cnt <= '0;
        else                 tmo_cnt <= tmo_cnt + TW'(1);
        if ((fire && !sel_lock) || tmo_hit) ptr <= next_idx(owner);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_arbiter
// Purpose  : Self-checking bench for updown_counter_arbiter: a vector table,
//            hand-written lock/timeout/reset/priority sequences, and a
//            randomized phase compared against a behavioural model.
// Config   : UPDOWN_ARB_SAT_EN - selects saturating expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int TMO = 8;
`ifdef UPDOWN_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_data;
  logic [N-1:0]     req_lock;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     count;
  logic [1:0]       grant_id;
  logic             locked;
  logic             wrap_up;
  logic             wrap_down;
  logic             lock_timeout;

  always #5 clk = ~clk;

  updown_counter_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .LOCK_TMO (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .count        (count),
    .grant_id     (grant_id),
    .locked       (locked),
    .wrap_up      (wrap_up),
    .wrap_down    (wrap_down),
    .lock_timeout (lock_timeout)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [N-1:0] ready_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_count, m_ptr, m_gid, m_owner, m_tmo;
  bit m_locked, m_wu, m_wd, m_lt;

  function automatic int m_pick(input logic [N-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_step(input bit rst);
    int g, op, maxv;
    maxv = (1 << W) - 1;
    m_wu = 0; m_wd = 0; m_lt = 0;
    if (rst) begin
      m_count = 0; m_ptr = 0; m_gid = 0; m_owner = 0; m_tmo = 0; m_locked = 0;
      return;
    end
    g = m_pick(req_valid);
    if (g >= 0) begin
      op = int'(req_op[2*g +: 2]);
      case (op)
        0: if (m_count == maxv) begin m_wu = 1; m_count = SAT ? maxv : 0; end
           else m_count = m_count + 1;
        1: if (m_count == 0) begin m_wd = 1; m_count = SAT ? 0 : maxv; end
           else m_count = m_count - 1;
        2: m_count = int'(req_data[W*g +: W]);
        default: m_count = 0;
      endcase
      m_gid = g;
      if (!m_locked) begin
        m_ptr = (g + 1) % N;
        if (req_lock[g]) begin m_locked = 1; m_owner = g; m_tmo = 0; end
      end else begin
        m_tmo = 0;
        if (!req_lock[g]) begin m_locked = 0; m_ptr = (m_owner + 1) % N; end
      end
    end else if (m_locked) begin
      m_tmo = m_tmo + 1;
      if (m_tmo == TMO) begin
        m_locked = 0; m_lt = 1; m_tmo = 0; m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  // One clock of stimulus with full model comparison.
  task automatic apply(input bit rst, input logic [N-1:0] v, input logic [2*N-1:0] op,
                       input logic [W*N-1:0] d, input logic [N-1:0] lk);
    int g;
    logic [N-1:0] exp_rdy;
    reset = rst; req_valid = v; req_op = op; req_data = d; req_lock = lk;
    #3;
    g = m_pick(v);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    ready_s = req_ready;
    chk("ready", 32'(ready_s), 32'(exp_rdy));
    @(posedge clk);
    m_step(rst);
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("wrap_up", 32'(wrap_up), 32'(m_wu));
    chk("wrap_down", 32'(wrap_down), 32'(m_wd));
    chk("lock_timeout", 32'(lock_timeout), 32'(m_lt));
  endtask

  typedef struct {
    bit             rst;
    logic [N-1:0]   v;
    logic [2*N-1:0] op;
    logic [W*N-1:0] d;
    logic [N-1:0]   lk;
    logic [N-1:0]   e_rdy;
    logic [W-1:0]   e_cnt;
    logic [1:0]     e_gid;
    bit             e_wu;
    bit             e_wd;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int quiet;
    logic [N-1:0] rv;
    quiet = 0;

    // Reset sequence then the 8 round-robin increments.
    tbl[0] = '{1'b1, 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 4'hF, 8'h00, 16'h0000, 4'h0, 4'(1 << ((i - 1) % 4)),
                 4'(i), 2'((i - 1) % 4), 1'b0, 1'b0};
    // Requester 1: load E, inc, inc, clear, dec.
    tbl[9]  = '{1'b0, 4'b0010, 8'h08, 16'h00E0, 4'h0, 4'b0010, 4'hE, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0010, 8'h00, 16'h0000, 4'h0, 4'b0010, 4'hF, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0010, 8'h00, 16'h0000, 4'h0, 4'b0010, SAT ? 4'hF : 4'h0, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, 8'h0C, 16'h0000, 4'h0, 4'b0010, 4'h0, 2'd1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'b0010, 8'h04, 16'h0000, 4'h0, 4'b0010, SAT ? 4'h0 : 4'hF, 2'd1, 1'b0, 1'b1};

    reset = 1'b1; req_valid = '0; req_op = '0; req_data = '0; req_lock = '0;
    m_step(1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].lk);
      chk("tbl_ready", 32'(ready_s), 32'(tbl[i].e_rdy));
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_grant_id", 32'(grant_id), 32'(tbl[i].e_gid));
      chk("tbl_wrap_up", 32'(wrap_up), 32'(tbl[i].e_wu));
      chk("tbl_wrap_down", 32'(wrap_down), 32'(tbl[i].e_wd));
    end

    // Lock by requester 2 while 0 and 3 wait (ptr is 2 here).
    apply(1'b0, 4'b1101, 8'h00, 16'h0, 4'b0100);
    chk("lock_grant", 32'(ready_s), 32'h4);
    chk("lock_set", 32'(locked), 32'h1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b1101, 8'h00, 16'h0, 4'b0100);
      chk("lock_stall", 32'(ready_s), 32'h4);
      chk("lock_hold", 32'(locked), 32'h1);
    end
    apply(1'b0, 4'b1101, 8'h00, 16'h0, 4'b0000);
    chk("unlock_grant", 32'(ready_s), 32'h4);
    chk("unlock_clear", 32'(locked), 32'h0);
    apply(1'b0, 4'b1001, 8'h00, 16'h0, 4'b0000);
    chk("post_unlock_grant", 32'(ready_s), 32'h8);

    // Lock by requester 0 then let it go idle until the timeout fires.
    apply(1'b0, 4'b0001, 8'h00, 16'h0, 4'b0001);
    for (int k = 0; k < TMO; k++) begin
      apply(1'b0, 4'b1000, 8'h00, 16'h0, 4'b0000);
      if (k < TMO - 1) chk("tmo_hold", 32'(locked), 32'h1);
      else             chk("tmo_pulse", 32'(lock_timeout), 32'h1);
    end
    apply(1'b0, 4'b1000, 8'h00, 16'h0, 4'b0000);
    chk("post_tmo_grant", 32'(ready_s), 32'h8);

    // Reset while locked, with a pending load from the owner.
    apply(1'b0, 4'b0010, 8'h00, 16'h0000, 4'b0010);
    apply(1'b0, 4'b0010, 8'h08, 16'h0090, 4'b0010);
    chk("pre_reset_count", 32'(count), 32'h9);
    apply(1'b1, 4'b0010, 8'h08, 16'h0050, 4'b0010);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    apply(1'b0, 4'b1111, 8'h00, 16'h0, 4'b0000);
    chk("reset_ptr", 32'(ready_s), 32'h1);

    // ptr -> 3, then requesters 0 and 3 collide.
    apply(1'b0, 4'b0100, 8'h00, 16'h0, 4'b0000);
    apply(1'b0, 4'b1001, 8'h80, 16'h7000, 4'b0000);
    chk("wrap_prio_first", 32'(ready_s), 32'h8);
    chk("wrap_prio_load", 32'(count), 32'h7);
    apply(1'b0, 4'b0001, 8'h00, 16'h0, 4'b0000);
    chk("wrap_prio_second", 32'(ready_s), 32'h1);
    chk("wrap_prio_inc", 32'(count), 32'h8);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rv = N'($urandom);
      if (quiet == 0 && $urandom_range(0, 15) == 0) quiet = $urandom_range(4, 12);
      if (quiet > 0) begin
        rv = rv & ~(N'(1) << m_owner);
        quiet--;
      end
      apply($urandom_range(0, 59) == 0, rv, (2*N)'($urandom), (W*N)'($urandom),
            ($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
